// File: rtl/full_adder_16bit_if.sv
// Operand/result bundle for full_adder_16bit; ovf exists only with FULL_ADDER_16BIT_OVF_EN.
interface full_adder_16bit_if;
  logic [15:0] A;
  logic [15:0] B;
  logic        cin;
  logic        in_valid;
  logic [15:0] S;
  logic        cout;
  logic        out_valid;
`ifdef FULL_ADDER_16BIT_OVF_EN
  logic        ovf;

  modport slave  (input A, B, cin, in_valid, output S, cout, out_valid, ovf);
  modport master (output A, B, cin, in_valid, input S, cout, out_valid, ovf);
`else
  modport slave  (input A, B, cin, in_valid, output S, cout, out_valid);
  modport master (output A, B, cin, in_valid, input S, cout, out_valid);
`endif
endinterface

// File: rtl/full_adder_16bit.sv
// Registered 16-bit adder: full-adder cells with two-level 4x4 carry lookahead.
// Optional signed-overflow output enabled by FULL_ADDER_16BIT_OVF_EN.
module full_adder_16bit_fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ c_i;
  assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module full_adder_16bit (
  input  logic               clk,
  input  logic               rst_n,
  full_adder_16bit_if.slave  bus
);
  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [15:0] co;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [3:0]  blk_c;

  logic [15:0] s_d, s_q;
  logic        cout_d, cout_q;
  logic        vld_q;

  assign g = bus.A & bus.B;
  assign p = bus.A ^ bus.B;

  always_comb begin
    grp_g = '0;
    grp_p = '0;
    blk_c = '0;
    c     = '0;
    for (int k = 0; k < 4; k++) begin
      grp_p[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
    // Second-level lookahead: block carries straight from group G/P and cin.
    blk_c[0] = bus.cin;
    blk_c[1] = grp_g[0] | (grp_p[0] & bus.cin);
    blk_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & bus.cin);
    blk_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[2] & grp_p[1] & grp_p[0] & bus.cin);
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = blk_c[k];
      c[4*k+1] = g[4*k] | (p[4*k] & blk_c[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & blk_c[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & blk_c[k]);
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_cell
    full_adder_16bit_fa_cell u_fa (
      .a_i  (bus.A[i]),
      .b_i  (bus.B[i]),
      .c_i  (c[i]),
      .s_o  (s_d[i]),
      .co_o (co[i])
    );
  end

  // Only the top cell's carry-out is consumed; the lower ones duplicate lookahead carries.
  assign cout_d = co[15];
  logic unused_carries;
  assign unused_carries = ^{grp_g[3], grp_p[3], co[14:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= bus.in_valid;
      if (bus.in_valid) begin
        s_q    <= s_d;
        cout_q <= cout_d;
      end
    end
  end

  assign bus.S         = s_q;
  assign bus.cout      = cout_q;
  assign bus.out_valid = vld_q;

`ifdef FULL_ADDER_16BIT_OVF_EN
  logic ovf_d, ovf_q;
  assign ovf_d = c[15] ^ cout_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (bus.in_valid) begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_full_adder_16bit.sv
// Directed-vector bench for full_adder_16bit; covers ovf when FULL_ADDER_16BIT_OVF_EN is set.
module tb_full_adder_16bit;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  full_adder_16bit_if bus ();

  full_adder_16bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs [10];

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [15:0] s, input logic co,
                           input logic ov, input logic vld);
    check_vec({tag, ".S"}, 32'(bus.S), 32'(s));
    check_vec({tag, ".cout"}, 32'(bus.cout), 32'(co));
    check_vec({tag, ".out_valid"}, 32'(bus.out_valid), 32'(vld));
`ifdef FULL_ADDER_16BIT_OVF_EN
    check_vec({tag, ".ovf"}, 32'(bus.ovf), 32'(ov));
`else
    if (ov !== ov) n_miss++;
`endif
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[1] = '{16'hB333, 16'h4444, 1'b0, 16'hF777, 1'b0, 1'b0};
    vecs[2] = '{16'hFFFF, 16'hD555, 1'b1, 16'hD555, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[8] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[9] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

    // Reset with a valid input present: it must be discarded.
    rst_n        = 1'b0;
    bus.A        = 16'h1234;
    bus.B        = 16'h1111;
    bus.cin      = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    check_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    @(posedge clk); #1;
    check_out("post_reset_idle", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Back-to-back vectors, one per cycle.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.A        = vecs[i].a;
      bus.B        = vecs[i].b;
      bus.cin      = vecs[i].ci;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      check_out($sformatf("vec%0d", i), vecs[i].s, vecs[i].co, vecs[i].ov, 1'b1);
    end

    // Idle with changing operands: outputs hold the last result.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.A        = 16'hFFFF;
      bus.B        = 16'h0001 + 16'(i);
      bus.cin      = 1'b1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      check_out($sformatf("hold%0d", i), 16'h1000, 1'b0, 1'b0, 1'b0);
    end

    // Mid-stream asynchronous reset between edges.
    @(negedge clk);
    bus.A        = 16'hC000;
    bus.B        = 16'h8000;
    bus.cin      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    check_out("pre_async", 16'h4000, 1'b1, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_out("rst_discard", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check_out("rst_release", 16'h0000, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    bus.A        = 16'h7FFF;
    bus.B        = 16'h0001;
    bus.cin      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    check_out("first_after_rst", 16'h8000, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check_out("final_hold", 16'h8000, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
